wb_pwm_bank: RTL

Parametrised Wishbone slave driving a bank of CHANNELS independent PWM outputs for LED drive. Successor to the fixed farbborg Wishbone/PWM wrapper: registered single-pulse ack, readback of every register, programmable prescaler, configurable PWM resolution, double-buffered duty values swapped at period boundaries, and a frame interrupt. Sits on the system Wishbone bus beside the other peripherals; all logic runs on the bus clock.

---
 rtl/wb_pwm_bank_if.sv | 21 ++
 rtl/wb_pwm_bank.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/wb_pwm_bank_if.sv
// rtl/wb_pwm_bank_if.sv - Wishbone slave bus bundle for the PWM bank
interface wb_pwm_bank_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_pwm_bank.sv
// rtl/wb_pwm_bank.sv - Wishbone slave with a bank of double-buffered PWM outputs
module wb_pwm_bank #(
  parameter int CHANNELS = 8,
  parameter int PWM_BITS = 8,
  parameter int PRE_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  wb_pwm_bank_if.slave        wb,
  output logic [CHANNELS-1:0] pwm_o,
  output logic                frame_o,
  output logic                irq_o
);

  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;
  logic                en_q, en_d, inv_q, inv_d, pend_q, pend_d, irqen_q, irqen_d;
  logic [PRE_BITS-1:0] pre_q, pre_d, pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                irq_flag_q, irq_flag_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic [PWM_BITS-1:0] shadow_q [CHANNELS];
  logic [PWM_BITS-1:0] shadow_d [CHANNELS];
  logic [PWM_BITS-1:0] active_q [CHANNELS];
  logic [PWM_BITS-1:0] active_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                sw_q, sw_d, frame_q, frame_d;

  logic        accept, wr, tick, wrap, swap;
  logic [5:0]  idx;
  logic [31:0] rdata;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    end
    return r;
  endfunction

  assign idx    = wb.wb_adr_i[7:2];
  assign accept = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wr     = accept & wb.wb_we_i;
  assign tick   = en_q && (pre_cnt_q == pre_q);
  assign wrap   = tick && (pwm_cnt_q == '1);
  assign swap   = wrap && pend_q;

  always_comb begin
    rdata = '0;
    case (idx)
      6'h00:   rdata[3:0] = {irqen_q, pend_q, inv_q, en_q};
      6'h01:   rdata = 32'(pre_q);
      6'h02:   rdata = {16'h0000, frame_cnt_q, 7'b0000000, irq_flag_q};
      default: begin
        for (int n = 0; n < CHANNELS; n++) begin
          if (idx == 6'(16 + n)) rdata = 32'(shadow_q[n]);
        end
      end
    endcase
  end

  always_comb begin
    ack_d       = accept;
    dat_d       = accept ? rdata : dat_q;
    en_d        = en_q;
    inv_d       = inv_q;
    pend_d      = pend_q;
    irqen_d     = irqen_q;
    pre_d       = pre_q;
    irq_flag_d  = irq_flag_q;
    frame_cnt_d = frame_cnt_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    pre_cnt_d   = '0;
    pwm_cnt_d   = '0;

    if (en_q) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_BITS'(1);
      pwm_cnt_d = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    end

    if (swap) begin
      active_d    = shadow_q;
      pend_d      = 1'b0;
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    // Bus writes follow the swap so a same-cycle SWAP request survives.
    if (wr) begin
      case (idx)
        6'h00: begin
          if (wb.wb_sel_i[0]) begin
            en_d    = wb.wb_dat_i[0];
            inv_d   = wb.wb_dat_i[1];
            irqen_d = wb.wb_dat_i[3];
            if (wb.wb_dat_i[2]) pend_d = 1'b1;
          end
        end
        6'h01: begin
          pre_d     = PRE_BITS'(merge(32'(pre_q), wb.wb_dat_i, wb.wb_sel_i));
          pre_cnt_d = '0;
        end
        6'h02: begin
          if (wb.wb_sel_i[0] && wb.wb_dat_i[0]) irq_flag_d = 1'b0;
        end
        default: begin
          for (int n = 0; n < CHANNELS; n++) begin
            if (idx == 6'(16 + n))
              shadow_d[n] = PWM_BITS'(merge(32'(shadow_q[n]), wb.wb_dat_i, wb.wb_sel_i));
          end
        end
      endcase
    end

    if (swap) irq_flag_d = 1'b1;

    for (int n = 0; n < CHANNELS; n++) begin
      pwm_d[n] = en_q ? ((pwm_cnt_q < active_q[n]) ^ inv_q) : inv_q;
    end
    // Delay the frame pulse so it lines up with the first cycle of new duties on pwm_o.
    sw_d    = swap;
    frame_d = sw_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      en_q        <= 1'b0;
      inv_q       <= 1'b0;
      pend_q      <= 1'b0;
      irqen_q     <= 1'b0;
      pre_q       <= '0;
      pre_cnt_q   <= '0;
      pwm_cnt_q   <= '0;
      irq_flag_q  <= 1'b0;
      frame_cnt_q <= '0;
      shadow_q    <= '{default: '0};
      active_q    <= '{default: '0};
      pwm_q       <= '0;
      sw_q        <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      en_q        <= en_d;
      inv_q       <= inv_d;
      pend_q      <= pend_d;
      irqen_q     <= irqen_d;
      pre_q       <= pre_d;
      pre_cnt_q   <= pre_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      irq_flag_q  <= irq_flag_d;
      frame_cnt_q <= frame_cnt_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pwm_q       <= pwm_d;
      sw_q        <= sw_d;
      frame_q     <= frame_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign pwm_o       = pwm_q;
  assign frame_o     = frame_q;
  assign irq_o       = irq_flag_q & irqen_q;

endmodule
